param_rr_stream_mux: RTL and testbench

- Next-generation parametrised N:1 multiplexer. Replaces the fixed 2/4/8:1 combinational mux trees with a single registered, handshaked selector.
- CHANNELS input streams, each with a valid/ready handshake, feed one output stream.
- Two selection modes:
  - Direct mode: the source is picked by an explicit select input, as the existing muxes do.
  - Round-robin mode: fair rotating arbitration among valid sources.
- Sits between datapath producers (ALU result sources, register-file read ports) and a single downstream consumer.

---
 rtl/param_rr_stream_mux.sv | 121 ++++++++++++
 tb/tb_param_rr_stream_mux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/param_rr_stream_mux.sv
// param_rr_stream_mux
//   Registered N:1 stream selector with valid/ready handshakes. One output
//   register stage: 1-cycle latency, and one word per cycle while out_ready
//   stays high. The source is chosen either directly by `sel` (mode = 0) or
//   by a rotating round-robin pointer among valid inputs (mode = 1).
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous reset, active low
//   mode      : 0 = direct select, 1 = round-robin
//   sel       : channel index used in direct mode
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (combinational, at most one bit high)
//   out_data  : registered output word
//   out_chan  : channel that supplied out_data
//   out_valid : output register holds a word
//   out_ready : downstream accepts the output word
module param_rr_stream_mux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [SEL_WIDTH-1:0]         out_chan,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic [SEL_WIDTH:0]   NUM_CH  = (SEL_WIDTH+1)'(CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CHANNELS - 1);

  logic [SEL_WIDTH-1:0] ptr_p1;
  logic                 vld_p1;
  logic [WIDTH-1:0]     data_p1;
  logic [SEL_WIDTH-1:0] chan_p1;

  logic                 can_load_p0;
  logic                 gnt_vld_p0;
  logic                 xfer_p0;
  logic [SEL_WIDTH-1:0] gnt_p0;
  logic [WIDTH-1:0]     gnt_data_p0;
  logic [SEL_WIDTH:0]   idx;

  // ---- stage p0: combinational grant and handshake ----
  // The round-robin search walks ptr, ptr+1, ... with an explicit wrap at
  // CHANNELS so non-power-of-two channel counts rotate correctly. Channel
  // indices are matched by comparison rather than variable bit-selects so an
  // out-of-range sel or index simply never matches.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_p0     = '0;
    idx        = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_WIDTH'(i) && in_valid[i]) begin
          gnt_vld_p0 = 1'b1;
          gnt_p0     = SEL_WIDTH'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = {1'b0, ptr_p1} + (SEL_WIDTH+1)'(k);
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        for (int i = 0; i < CHANNELS; i++) begin
          if (!gnt_vld_p0 && idx == (SEL_WIDTH+1)'(i) && in_valid[i]) begin
            gnt_vld_p0 = 1'b1;
            gnt_p0     = SEL_WIDTH'(i);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_p0 == SEL_WIDTH'(i)) begin
        gnt_data_p0 = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The register may load when it is empty or being drained this cycle.
  assign can_load_p0 = !vld_p1 || out_ready;
  assign xfer_p0     = rst && can_load_p0 && gnt_vld_p0;
  assign in_ready    = xfer_p0 ? (CHANNELS'(1) << gnt_p0) : '0;

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr_p1  <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= gnt_data_p0;
      chan_p1 <= gnt_p0;
      if (mode) begin
        ptr_p1 <= (gnt_p0 == LAST_CH) ? '0 : gnt_p0 + 1'b1;
      end
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_param_rr_stream_mux.sv
module tb_param_rr_stream_mux;
  localparam int W  = 8;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic              rst, mode, out_valid, out_ready;
  logic [SW-1:0]     sel, out_chan;
  logic [N*W-1:0]    in_data;
  logic [N-1:0]      in_valid, in_ready;
  logic [W-1:0]      out_data;

  // 5-channel instance (non-power-of-two wrap)
  logic              rst_5, mode_5, out_valid_5, out_ready_5;
  logic [SW-1:0]     sel_5, out_chan_5;
  logic [N5*W-1:0]   in_data_5;
  logic [N5-1:0]     in_valid_5, in_ready_5;
  logic [W-1:0]      out_data_5;

  param_rr_stream_mux #(.WIDTH(W), .CHANNELS(N), .SEL_WIDTH(SW)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  param_rr_stream_mux #(.WIDTH(W), .CHANNELS(N5), .SEL_WIDTH(SW)) u_dut5 (
    .clk(clk), .rst(rst_5), .mode(mode_5), .sel(sel_5), .in_data(in_data_5),
    .in_valid(in_valid_5), .in_ready(in_ready_5), .out_data(out_data_5),
    .out_chan(out_chan_5), .out_valid(out_valid_5), .out_ready(out_ready_5)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] valid;
    logic       ordy;
    logic [7:0] e_ready;
    logic       e_vld;
    logic [2:0] e_chan;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[18];

  // Reference grant: search in channel order from the pointer, modulo n.
  function automatic int ref_grant(input bit md, input int s, input logic [15:0] v,
                                   input int p, input int n);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  int          m_ptr, m_chan, g;
  bit          m_vld;
  logic [7:0]  m_data;
  logic [7:0]  exp_rdy;
  int          seq5[4];

  initial begin
    //              rst   mode  sel   valid   ordy  e_ready e_vld e_chan e_data
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15};
    tbl[4]  = '{1'b1, 1'b0, 3'd5, 8'hDF, 1'b1, 8'h00, 1'b0, 3'd5, 8'h15};
    tbl[5]  = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12};
    tbl[6]  = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15};
    tbl[7]  = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h80, 1'b1, 3'd7, 8'h17};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};
    tbl[9]  = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h04, 1'b1, 3'd2, 8'h12};
    tbl[10] = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[11] = '{1'b1, 1'b0, 3'd5, 8'hA5, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[12] = '{1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12};
    tbl[13] = '{1'b1, 1'b1, 3'd0, 8'hA5, 1'b1, 8'h20, 1'b1, 3'd5, 8'h15};
    tbl[14] = '{1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 8'h15};
    tbl[15] = '{1'b1, 1'b1, 3'd0, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'h13};
    tbl[16] = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00};
    tbl[17] = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'h10};

    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
    rst_5 = 1'b0; mode_5 = 1'b0; sel_5 = '0; in_valid_5 = '0; out_ready_5 = 1'b1;
    for (int i = 0; i < N5; i++) in_data_5[i*W +: W] = 8'(8'h40 + i);

    // Table-driven directed vectors on the 8-channel instance
    for (int r = 0; r < 18; r++) begin
      rst = tbl[r].rst; mode = tbl[r].mode; sel = tbl[r].sel;
      in_valid = tbl[r].valid; out_ready = tbl[r].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].e_ready);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_vld);
      chk($sformatf("tbl%0d_out_chan", r), out_chan, tbl[r].e_chan);
      chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].e_data);
    end

    // Randomised traffic against the reference model
    m_ptr = 0; m_vld = 0; m_data = '0; m_chan = 0;
    for (int c = 0; c < 400; c++) begin
      rst       = (c == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      g = ref_grant(mode, int'(sel), 16'(in_valid), m_ptr, N);
      exp_rdy = (rst && (!m_vld || out_ready) && g >= 0) ? 8'(1 << g) : 8'h00;
      #1;
      chk("rnd_in_ready", in_ready, exp_rdy);
      @(posedge clk);
      if (!rst) begin
        m_vld = 0; m_data = '0; m_chan = 0; m_ptr = 0;
      end else if (exp_rdy != 0) begin
        m_vld = 1; m_data = in_data[g*W +: W]; m_chan = g;
        if (mode) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_vld = 0;
      end
      #1;
      chk("rnd_out_valid", out_valid, m_vld);
      chk("rnd_out_chan", out_chan, m_chan);
      chk("rnd_out_data", out_data, m_data);
    end

    // Non-power-of-two wrap on the 5-channel instance
    rst_5 = 1'b0;
    @(posedge clk); #1;
    chk("c5_reset_valid", out_valid_5, 0);
    rst_5 = 1'b1; mode_5 = 1'b1; in_valid_5 = 5'b10001; out_ready_5 = 1'b1;
    seq5 = '{0, 4, 0, 4};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("c5_rr%0d_ready", k), in_ready_5, 32'(1 << seq5[k]));
      @(posedge clk); #1;
      chk($sformatf("c5_rr%0d_chan", k), out_chan_5, seq5[k]);
      chk($sformatf("c5_rr%0d_data", k), out_data_5, 8'h40 + seq5[k]);
      chk($sformatf("c5_rr%0d_valid", k), out_valid_5, 1);
    end
    // Direct select beyond the channel count: no grant, register drains
    mode_5 = 1'b0; sel_5 = 3'd6; in_valid_5 = 5'b11111;
    #1;
    chk("c5_sel6_ready", in_ready_5, 0);
    @(posedge clk); #1;
    chk("c5_sel6_valid", out_valid_5, 0);
    chk("c5_sel6_chan", out_chan_5, 4);
    sel_5 = 3'd4;
    #1;
    chk("c5_sel4_ready", in_ready_5, 5'b10000);
    @(posedge clk); #1;
    chk("c5_sel4_chan", out_chan_5, 4);
    chk("c5_sel4_data", out_data_5, 8'h44);
    // Pointer wrapped to 0 after the last round-robin grant of channel 4
    mode_5 = 1'b1;
    #1;
    chk("c5_wrap_ready", in_ready_5, 5'b00001);
    @(posedge clk); #1;
    chk("c5_wrap_chan", out_chan_5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
